matmul_job_arbiter: RTL and testbench
=====================================

# matmul_job_arbiter

Shares the single 4x4 matrix-multiply engine between two AXI-Stream requesters. Each job is 32 input words (A row-major, then B row-major) followed by 16 result words (C row-major). The arbiter grants one requester per job in round-robin order and forwards its input beats to the engine. It then routes the engine's 16 result beats back to that requester's output stream and generates TLAST on the last one. It sits between the two requester stream ports and the engine's ss_*/sm_* ports.

## Interface
- pDATA_WIDTH, 32, stream data width (must match engine)
- axis_clk  in  1  clock, all logic on rising edge
- axis_rst_n  in  1  asynchronous, active-high reset (name retained from codebase)
- s0_tvalid / s0_tready / s0_tlast  in/out/in  1  requester 0 job input handshake
- s0_tdata  in  pDATA_WIDTH  requester 0 job word
- s1_tvalid / s1_tready / s1_tlast / s1_tdata  as s0, requester 1
- m0_tvalid / m0_tready / m0_tlast  out/in/out  1  requester 0 result handshake
- m0_tdata  out  pDATA_WIDTH  requester 0 result word
- m1_tvalid / m1_tready / m1_tlast / m1_tdata  as m0, requester 1
- eng_ss_tvalid / eng_ss_tready / eng_ss_tlast  out/in/out  1  to engine input stream
- eng_ss_tdata  out  pDATA_WIDTH  to engine
- eng_sm_tvalid / eng_sm_tready / eng_sm_tlast  in/out/in  1  from engine result stream (eng_sm_tlast ignored)
- eng_sm_tdata  in  pDATA_WIDTH  from engine
- grant  out  2  one-hot current owner, 2'b00 when idle
- busy  out  1  high in FEED or DRAIN
- err_len  out  1  sticky framing error

## Operation
- States: IDLE, FEED, DRAIN. Reset -> IDLE, word counter 0, last_grant = 1 (requester 0 wins first tie), err_len 0.
- IDLE: s0_tvalid|s1_tvalid -> register the grant and move to FEED next cycle. If only one requester is valid, it wins. If both are valid, the one not equal to last_grant wins. No tready asserted in IDLE.
- FEED: combinational pass-through. eng_ss_tvalid = sX_tvalid, sX_tready = eng_ss_tready, eng_ss_tdata = sX_tdata. eng_ss_tlast is high on beat 31.
  - 5-bit counter counts eng_ss_tvalid&&eng_ss_tready beats.
  - Beat 31 accepted -> DRAIN, counter cleared.
- DRAIN: mX_tvalid = eng_sm_tvalid, eng_sm_tready = mX_tready, mX_tdata = eng_sm_tdata. mX_tlast is high on beat 15 only.
  - Beat 15 accepted -> IDLE, last_grant <= X, counter cleared.
- Non-granted ports: tready 0, tvalid 0, tlast 0, tdata 0. In IDLE all engine-side valids/readies are 0 and eng_ss_tdata is 0.
- Framing is count-based. If sX_tlast is high on a beat other than 31, or low on beat 31, err_len is set. err_len is cleared only by reset, and the job continues normally.
- A requester asserting tvalid during another's job waits. No preemption.
- Reset mid-job: immediate return to IDLE and all outputs to reset values. The engine must share the same reset, so no partial job survives.

## Timing
- Reset values: every tvalid, tready, tlast, grant, busy and err_len = 0; every tdata = 0.
- Grant latency: 1 cycle from the first IDLE cycle with tvalid to the first possible sX_tready.
- Zero added latency per beat in FEED and DRAIN. Backpressure passes through combinationally in both directions.
- Turnaround: at least one IDLE cycle between the last result beat of one job and the first input beat of the next.
- busy rises with entry to FEED and falls on the cycle after the final result beat.

## Configuration
- MATMUL_ARB_STATS_EN defined: adds outputs job_cnt0 and job_cnt1, 16 bits each.
  - Each counter increments on its requester's final result beat and wraps at 0xFFFF -> 0.
  - Reset value 0.
- MATMUL_ARB_STATS_EN undefined: these ports and their counters do not exist. All other behaviour is identical.

## Structure
- Shared package matmul_pkg contains:
  - MM_IN_WORDS = 32, MM_OUT_WORDS = 16
  - state enum {IDLE, FEED, DRAIN}
  - grant typedef (2-bit one-hot)
- One sub-module, matmul_rr_arb: 2-way round-robin picker. Inputs are the two requests and last_grant; output is a one-hot pick.
- Counter, FSM and stream muxing live in the top level.

## Test plan
- Only s0 sends A = identity, B = 1..16 with tlast on beat 31 -> m0 receives 1..16, m0_tlast on the 16th beat only, s1/m1 idle, err_len 0.
- s0 and s1 both valid from reset -> s0 served first, then s1. With both continuously requesting, grants alternate 0,1,0,1 over 4 jobs.
- m1_tready toggling 1/0 each cycle during DRAIN -> eng_sm_tready mirrors it, no result lost or duplicated, 16 beats total.
- s0 asserts tlast on beat 20 -> err_len stays 1 after that beat, job still completes after 32 input beats, results correct.
- Reset asserted on beat 10 of FEED -> next cycle grant = 0, busy = 0, all tvalid/tready = 0. The subsequent fresh s1 job completes correctly.
- With MATMUL_ARB_STATS_EN: 3 s0 jobs and 2 s1 jobs -> job_cnt0 = 3, job_cnt1 = 2.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply job arbiter: job word counts,
// FSM state encoding and the one-hot grant type.
package matmul_pkg;

  localparam int MM_IN_WORDS  = 32;
  localparam int MM_OUT_WORDS = 16;
  localparam int MM_CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef logic [1:0] grant_t;

  localparam grant_t GRANT_NONE = 2'b00;
  localparam grant_t GRANT_0    = 2'b01;
  localparam grant_t GRANT_1    = 2'b10;

endpackage

// File: rtl/matmul_rr_arb.sv
// Two-way round-robin picker: a lone requester wins, on a tie the requester
// that did not own the previous job wins. Purely combinational.
module matmul_rr_arb
  import matmul_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  logic   last_grant,
  output grant_t pick
);

  always_comb begin
    pick = GRANT_NONE;
    if (req0 && req1) begin
      pick = last_grant ? GRANT_0 : GRANT_1;
    end else if (req0) begin
      pick = GRANT_0;
    end else if (req1) begin
      pick = GRANT_1;
    end
  end

endmodule

// File: rtl/matmul_job_arbiter.sv
// Shares one 4x4 matmul engine between two AXI-Stream requesters, one job at a
// time. Optional per-requester job counters when MATMUL_ARB_STATS_EN is defined.
module matmul_job_arbiter
  import matmul_pkg::*;
#(
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,

  input  logic                   s0_tvalid,
  output logic                   s0_tready,
  input  logic                   s0_tlast,
  input  logic [pDATA_WIDTH-1:0] s0_tdata,
  input  logic                   s1_tvalid,
  output logic                   s1_tready,
  input  logic                   s1_tlast,
  input  logic [pDATA_WIDTH-1:0] s1_tdata,

  output logic                   m0_tvalid,
  input  logic                   m0_tready,
  output logic                   m0_tlast,
  output logic [pDATA_WIDTH-1:0] m0_tdata,
  output logic                   m1_tvalid,
  input  logic                   m1_tready,
  output logic                   m1_tlast,
  output logic [pDATA_WIDTH-1:0] m1_tdata,

  output logic                   eng_ss_tvalid,
  input  logic                   eng_ss_tready,
  output logic                   eng_ss_tlast,
  output logic [pDATA_WIDTH-1:0] eng_ss_tdata,
  input  logic                   eng_sm_tvalid,
  output logic                   eng_sm_tready,
  input  logic                   eng_sm_tlast,
  input  logic [pDATA_WIDTH-1:0] eng_sm_tdata,

  output logic [1:0]             grant,
  output logic                   busy,
  output logic                   err_len
`ifdef MATMUL_ARB_STATS_EN
  ,
  output logic [15:0]            job_cnt0,
  output logic [15:0]            job_cnt1
`endif
);

  state_e                state_q, state_d;
  logic [MM_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;
  grant_t                grant_q, grant_d;
  logic                  err_len_q, err_len_d;

  grant_t                pick;
  logic                  in_feed, in_drain;
  logic                  sel1;
  logic                  s_tvalid_sel, s_tlast_sel;
  logic [pDATA_WIDTH-1:0] s_tdata_sel;
  logic                  m_tready_sel;
  logic                  last_in, last_out;
  logic                  feed_hs, drain_hs, job_done;

  // Engine result framing comes from the beat counter, not the engine's tlast.
  logic                  unused_sm_tlast;
  assign unused_sm_tlast = eng_sm_tlast;

  matmul_rr_arb u_rr_arb (
    .req0       (s0_tvalid),
    .req1       (s1_tvalid),
    .last_grant (last_grant_q),
    .pick       (pick)
  );

  assign in_feed  = (state_q == FEED);
  assign in_drain = (state_q == DRAIN);
  assign sel1     = grant_q[1];
  assign last_in  = (cnt_q == MM_CNT_W'(MM_IN_WORDS - 1));
  assign last_out = (cnt_q == MM_CNT_W'(MM_OUT_WORDS - 1));

  assign s_tvalid_sel = sel1 ? s1_tvalid : s0_tvalid;
  assign s_tlast_sel  = sel1 ? s1_tlast  : s0_tlast;
  assign s_tdata_sel  = sel1 ? s1_tdata  : s0_tdata;
  assign m_tready_sel = sel1 ? m1_tready : m0_tready;

  assign feed_hs  = eng_ss_tvalid && eng_ss_tready;
  assign drain_hs = eng_sm_tvalid && eng_sm_tready;
  assign job_done = drain_hs && last_out;

  // Combinational stream steering; everything not owned by the grant is zero.
  always_comb begin
    eng_ss_tvalid = 1'b0;
    eng_ss_tlast  = 1'b0;
    eng_ss_tdata  = '0;
    eng_sm_tready = 1'b0;
    s0_tready     = 1'b0;
    s1_tready     = 1'b0;
    m0_tvalid     = 1'b0;
    m0_tlast      = 1'b0;
    m0_tdata      = '0;
    m1_tvalid     = 1'b0;
    m1_tlast      = 1'b0;
    m1_tdata      = '0;
    if (in_feed) begin
      eng_ss_tvalid = s_tvalid_sel;
      eng_ss_tlast  = last_in;
      eng_ss_tdata  = s_tdata_sel;
      s0_tready     = grant_q[0] && eng_ss_tready;
      s1_tready     = grant_q[1] && eng_ss_tready;
    end
    if (in_drain) begin
      eng_sm_tready = m_tready_sel;
      if (grant_q[0]) begin
        m0_tvalid = eng_sm_tvalid;
        m0_tlast  = last_out;
        m0_tdata  = eng_sm_tdata;
      end
      if (grant_q[1]) begin
        m1_tvalid = eng_sm_tvalid;
        m1_tlast  = last_out;
        m1_tdata  = eng_sm_tdata;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    err_len_d    = err_len_q;
    case (state_q)
      IDLE: begin
        if (s0_tvalid || s1_tvalid) begin
          state_d = FEED;
          grant_d = pick;
        end
      end
      FEED: begin
        if (feed_hs) begin
          cnt_d = cnt_q + 1'b1;
          if (s_tlast_sel != last_in) begin
            err_len_d = 1'b1;
          end
          if (last_in) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_hs) begin
          cnt_d = cnt_q + 1'b1;
          if (last_out) begin
            state_d      = IDLE;
            cnt_d        = '0;
            last_grant_d = grant_q[1];
            grant_d      = GRANT_NONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        grant_d = GRANT_NONE;
      end
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_rst_n) begin
    if (axis_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= GRANT_NONE;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      err_len_q    <= err_len_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign err_len = err_len_q;

`ifdef MATMUL_ARB_STATS_EN
  logic [15:0] job_cnt0_q, job_cnt0_d;
  logic [15:0] job_cnt1_q, job_cnt1_d;

  always_comb begin
    job_cnt0_d = job_cnt0_q;
    job_cnt1_d = job_cnt1_q;
    if (job_done && grant_q[0]) begin
      job_cnt0_d = job_cnt0_q + 16'd1;
    end
    if (job_done && grant_q[1]) begin
      job_cnt1_d = job_cnt1_q + 16'd1;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst_n) begin
    if (axis_rst_n) begin
      job_cnt0_q <= '0;
      job_cnt1_q <= '0;
    end else begin
      job_cnt0_q <= job_cnt0_d;
      job_cnt1_q <= job_cnt1_d;
    end
  end

  assign job_cnt0 = job_cnt0_q;
  assign job_cnt1 = job_cnt1_q;
`else
  logic unused_job_done;
  assign unused_job_done = job_done;
`endif

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Directed bench for matmul_job_arbiter: the bench plays both requesters and
// the matmul engine, and checks routing, framing, arbitration and reset.
module tb_matmul_job_arbiter;

  localparam int W = 32;

  logic         axis_clk = 1'b0;
  logic         axis_rst_n;
  logic         s0_tvalid, s0_tready, s0_tlast;
  logic [W-1:0] s0_tdata;
  logic         s1_tvalid, s1_tready, s1_tlast;
  logic [W-1:0] s1_tdata;
  logic         m0_tvalid, m0_tready, m0_tlast;
  logic [W-1:0] m0_tdata;
  logic         m1_tvalid, m1_tready, m1_tlast;
  logic [W-1:0] m1_tdata;
  logic         eng_ss_tvalid, eng_ss_tready, eng_ss_tlast;
  logic [W-1:0] eng_ss_tdata;
  logic         eng_sm_tvalid, eng_sm_tready, eng_sm_tlast;
  logic [W-1:0] eng_sm_tdata;
  logic [1:0]   grant;
  logic         busy, err_len;
`ifdef MATMUL_ARB_STATS_EN
  logic [15:0]  job_cnt0, job_cnt1;
`endif

  matmul_job_arbiter #(.pDATA_WIDTH(W)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tlast(s0_tlast), .s0_tdata(s0_tdata),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tlast(s1_tlast), .s1_tdata(s1_tdata),
    .m0_tvalid(m0_tvalid), .m0_tready(m0_tready), .m0_tlast(m0_tlast), .m0_tdata(m0_tdata),
    .m1_tvalid(m1_tvalid), .m1_tready(m1_tready), .m1_tlast(m1_tlast), .m1_tdata(m1_tdata),
    .eng_ss_tvalid(eng_ss_tvalid), .eng_ss_tready(eng_ss_tready),
    .eng_ss_tlast(eng_ss_tlast), .eng_ss_tdata(eng_ss_tdata),
    .eng_sm_tvalid(eng_sm_tvalid), .eng_sm_tready(eng_sm_tready),
    .eng_sm_tlast(eng_sm_tlast), .eng_sm_tdata(eng_sm_tdata),
    .grant(grant), .busy(busy), .err_len(err_len)
`ifdef MATMUL_ARB_STATS_EN
    , .job_cnt0(job_cnt0), .job_cnt1(job_cnt1)
`endif
  );

  always #5 axis_clk = ~axis_clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int         who;
    int         pat;
    int         tl_beat;
    bit         tog;
    bit         both;
    logic [1:0] exp_g;
    bit         exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] gen(input int pat, input int idx);
    case (pat)
      0:       gen = (idx < 16) ? (((idx / 4) == (idx % 4)) ? 32'd1 : 32'd0) : 32'(idx - 15);
      1:       gen = 32'(idx * 3 + 1);
      2:       gen = 32'hFFFF_0000 + 32'(idx * 5);
      3:       gen = 32'(idx ^ 7);
      default: gen = 32'((idx % 5) + 2);
    endcase
  endfunction

  task automatic drive_s(input int who, input bit v, input logic [31:0] d, input bit l);
    if (who == 0) begin
      s0_tvalid = v; s0_tdata = d; s0_tlast = l;
    end else begin
      s1_tvalid = v; s1_tdata = d; s1_tlast = l;
    end
  endtask

  task automatic run_job(input vec_t v, input string nm);
    logic [31:0] w[32];
    logic [31:0] exp_c[16];
    logic [31:0] ein[32];
    logic [31:0] eng_c[16];
    logic [31:0] got[16];
    int beat, cyc, bad_data, bad_last, bad_mirror, bad_other, bad_err;
    logic [1:0] g_seen;
    logic rdy_x, mv, ml, mrdy;
    logic [31:0] md;
    for (int i = 0; i < 32; i++) begin
      w[i] = gen(v.pat, i);
      ein[i] = '0;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        exp_c[r*4+c] = '0;
        got[r*4+c] = '0;
        for (int k = 0; k < 4; k++) exp_c[r*4+c] += w[r*4+k] * w[16+k*4+c];
      end
    bad_data = 0; bad_last = 0; bad_mirror = 0; bad_other = 0; bad_err = 0;
    g_seen = 2'b11;
    beat = 0; cyc = 0;
    while (beat < 32 && cyc < 400) begin
      @(negedge axis_clk);
      drive_s(v.who, 1'b1, w[beat], beat == v.tl_beat);
      drive_s(1 - v.who, v.both, 32'hDEAD_0000 + 32'(beat), 1'b0);
      eng_ss_tready = v.tog ? (cyc % 3 != 2) : 1'b1;
      eng_sm_tvalid = 1'b0;
      m0_tready = 1'b1; m1_tready = 1'b1;
      #1;
      rdy_x = (v.who == 0) ? s0_tready : s1_tready;
      if (busy) begin
        if (rdy_x !== eng_ss_tready) bad_mirror++;
      end else if (eng_ss_tvalid || rdy_x) bad_other++;
      if (((v.who == 0) ? s1_tready : s0_tready) || m0_tvalid || m1_tvalid || eng_sm_tready)
        bad_other++;
      if (v.exp_err ? (beat > v.tl_beat && err_len !== 1'b1) : (err_len !== 1'b0)) bad_err++;
      if (eng_ss_tvalid && eng_ss_tready) begin
        if (beat == 0) g_seen = grant;
        ein[beat] = eng_ss_tdata;
        if (eng_ss_tlast !== (beat == 31)) bad_last++;
        beat++;
      end
      cyc++;
    end
    chk({nm, "_feed_beats"}, beat, 32);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        eng_c[r*4+c] = '0;
        for (int k = 0; k < 4; k++) eng_c[r*4+c] += ein[r*4+k] * ein[16+k*4+c];
      end
    beat = 0; cyc = 0;
    while (beat < 16 && cyc < 400) begin
      @(negedge axis_clk);
      drive_s(v.who, v.both, 32'h0, 1'b0);
      drive_s(1 - v.who, v.both, 32'hBEEF_0000, 1'b0);
      eng_ss_tready = 1'b1;
      eng_sm_tvalid = 1'b1;
      eng_sm_tdata = eng_c[beat];
      mrdy = v.tog ? ((cyc % 2) == 0) : 1'b1;
      if (v.who == 0) begin m0_tready = mrdy; m1_tready = 1'b1; end
      else begin m1_tready = mrdy; m0_tready = 1'b1; end
      #1;
      mv = (v.who == 0) ? m0_tvalid : m1_tvalid;
      ml = (v.who == 0) ? m0_tlast  : m1_tlast;
      md = (v.who == 0) ? m0_tdata  : m1_tdata;
      if (eng_sm_tready !== mrdy || mv !== eng_sm_tvalid) bad_mirror++;
      if (eng_ss_tvalid || s0_tready || s1_tready || !busy ||
          ((v.who == 0) ? m1_tvalid : m0_tvalid)) bad_other++;
      if (err_len !== v.exp_err) bad_err++;
      if (mv && mrdy) begin
        got[beat] = md;
        if (ml !== (beat == 15)) bad_last++;
        beat++;
      end
      cyc++;
    end
    chk({nm, "_drain_beats"}, beat, 16);
    @(negedge axis_clk);
    eng_sm_tvalid = 1'b0;
    m0_tready = 1'b0; m1_tready = 1'b0;
    drive_s(0, v.both, 32'h0, 1'b0);
    drive_s(1, v.both, 32'h0, 1'b0);
    #1;
    chk({nm, "_idle_after"},
        {24'h0, busy, grant, eng_ss_tvalid, eng_sm_tready, s0_tready, s1_tready, m0_tvalid | m1_tvalid}, 32'h0);
    for (int i = 0; i < 16; i++) if (got[i] !== exp_c[i]) bad_data++;
    chk({nm, "_results"}, bad_data, 0);
    chk({nm, "_grant"}, {30'h0, g_seen}, {30'h0, v.exp_g});
    chk({nm, "_tlast"}, bad_last, 0);
    chk({nm, "_mirror"}, bad_mirror, 0);
    chk({nm, "_other_quiet"}, bad_other, 0);
    chk({nm, "_err_track"}, bad_err, 0);
    chk({nm, "_err_len"}, {31'h0, err_len}, {31'h0, v.exp_err});
  endtask

  initial begin
    int beat, cyc;
    vecs[0] = '{0, 1, 31, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[1] = '{1, 2, 31, 1'b0, 1'b1, 2'b10, 1'b0};
    vecs[2] = '{0, 3, 31, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[3] = '{1, 4, 31, 1'b0, 1'b1, 2'b10, 1'b0};
    vecs[4] = '{0, 0, 31, 1'b0, 1'b0, 2'b01, 1'b0};
    vecs[5] = '{1, 2, 31, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[6] = '{0, 4, 20, 1'b0, 1'b0, 2'b01, 1'b1};

    // Reset with every input active: outputs must still sit at reset values.
    axis_rst_n = 1'b1;
    s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 32'h1111_1111;
    s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = 32'h2222_2222;
    m0_tready = 1'b1; m1_tready = 1'b1;
    eng_ss_tready = 1'b1;
    eng_sm_tvalid = 1'b1; eng_sm_tlast = 1'b0; eng_sm_tdata = 32'h3333_3333;
    repeat (3) @(posedge axis_clk);
    #1;
    chk("reset_grant", {30'h0, grant}, 32'h0);
    chk("reset_busy_err", {30'h0, busy, err_len}, 32'h0);
    chk("reset_handshake",
        {22'h0, s0_tready, s1_tready, m0_tvalid, m1_tvalid, eng_ss_tvalid, eng_sm_tready,
         m0_tlast, m1_tlast, eng_ss_tlast, 1'b0}, 32'h0);
    chk("reset_tdata", m0_tdata | m1_tdata | eng_ss_tdata, 32'h0);
`ifdef MATMUL_ARB_STATS_EN
    chk("reset_job_cnt", {job_cnt0, job_cnt1}, 32'h0);
`endif
    @(negedge axis_clk);
    axis_rst_n = 1'b0;
    eng_sm_tvalid = 1'b0;
    s0_tlast = 1'b0; s1_tlast = 1'b0;
    #1;
    chk("idle_no_tready", {30'h0, s0_tready, s1_tready}, 32'h0);

    for (int i = 0; i < 7; i++) run_job(vecs[i], $sformatf("job%0d", i));

`ifdef MATMUL_ARB_STATS_EN
    chk("job_cnt0", {16'h0, job_cnt0}, 32'd4);
    chk("job_cnt1", {16'h0, job_cnt1}, 32'd3);
`endif

    // Reset in the middle of a FEED phase, after 10 accepted beats.
    beat = 0; cyc = 0;
    while (beat < 10 && cyc < 50) begin
      @(negedge axis_clk);
      drive_s(0, 1'b1, 32'(beat + 100), 1'b0);
      drive_s(1, 1'b0, 32'h0, 1'b0);
      eng_ss_tready = 1'b1;
      #1;
      if (eng_ss_tvalid && eng_ss_tready) beat++;
      cyc++;
    end
    chk("midreset_beats", beat, 10);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(posedge axis_clk);
    #1;
    chk("midreset_grant_busy", {29'h0, grant, busy}, 32'h0);
    chk("midreset_handshake",
        {26'h0, s0_tready, s1_tready, m0_tvalid, m1_tvalid, eng_ss_tvalid, eng_sm_tready}, 32'h0);
    chk("midreset_err_len", {31'h0, err_len}, 32'h0);
`ifdef MATMUL_ARB_STATS_EN
    chk("midreset_job_cnt", {job_cnt0, job_cnt1}, 32'h0);
`endif
    @(negedge axis_clk);
    axis_rst_n = 1'b0;
    drive_s(0, 1'b0, 32'h0, 1'b0);
    run_job('{1, 3, 31, 1'b0, 1'b0, 2'b10, 1'b0}, "post_reset_s1");
`ifdef MATMUL_ARB_STATS_EN
    chk("post_reset_job_cnt", {job_cnt0, job_cnt1}, 32'h0000_0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
